siteswap_sequencer: RTL

//  Collects a siteswap juggling pattern one digit at a time (button/UART front end).

---
 rtl/siteswap_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/siteswap_sequencer.sv
// Siteswap entry buffer: collects throw digits, checks the pattern is collision-free,
// derives ball count, then holds the validated configuration. Build macro: SITESWAP_REJECT_ZERO_EN.
module siteswap_sequencer #(
    parameter int MAX_LEN = 7,
    parameter int DIGIT_W = 3
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [DIGIT_W-1:0]         digit_in,
    input  logic                       digit_valid_in,
    input  logic                       commit_in,
    input  logic                       clear_in,
    output logic [MAX_LEN*DIGIT_W-1:0] pattern_out,
    output logic [2:0]                 period_out,
    output logic [2:0]                 num_balls_out,
    output logic                       pattern_valid_out,
    output logic                       busy_out,
    output logic                       error_out,
    output logic [1:0]                 error_code_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_DIVIDE,
        S_PRESENT,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_OVERFLOW = 2'd0;
    localparam logic [1:0] ERR_EMPTY    = 2'd1;
    localparam logic [1:0] ERR_INVALID  = 2'd2;
`ifdef SITESWAP_REJECT_ZERO_EN
    localparam logic [1:0] ERR_ZERO     = 2'd3;
`endif
    localparam logic [2:0] LEN_MAX      = 3'(MAX_LEN);

    state_t               state_reg;
    logic [DIGIT_W-1:0]   buf_reg     [MAX_LEN];
    logic [DIGIT_W-1:0]   pattern_reg [MAX_LEN];
    logic [2:0]           len_reg;
    logic [2:0]           idx_reg;
    logic                 phase_reg;
    logic [3:0]           acc_reg;
    logic [5:0]           sum_reg;
    logic [5:0]           rem_reg;
    logic [2:0]           quot_reg;
    logic [MAX_LEN-1:0]   mask_reg;
    logic [2:0]           period_reg;
    logic [2:0]           balls_reg;
    logic                 valid_reg;
    logic                 busy_reg;
    logic                 error_reg;
    logic [1:0]           code_reg;

    logic [DIGIT_W-1:0]   cur_digit;
    logic [3:0]           step_sum;
    logic [3:0]           cand;
    logic [3:0]           len4;
    logic [5:0]           len6;
    logic [5:0]           sum_next;
    logic [2:0]           land;
    logic                 land_ok;

    // Landing slot search: phase 0 starts from i+p[i], phase 1 continues from the residue.
    assign cur_digit = buf_reg[idx_reg];
    assign step_sum  = {1'b0, idx_reg} + 4'(cur_digit);
    assign cand      = phase_reg ? acc_reg : step_sum;
    assign len4      = {1'b0, len_reg};
    assign len6      = {3'b000, len_reg};
    assign land      = cand[2:0];
    assign land_ok   = (cand < len4);
    assign sum_next  = sum_reg + 6'(cur_digit);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || clear_in) begin
            state_reg  <= S_IDLE;
            for (int k = 0; k < MAX_LEN; k++) begin
                buf_reg[k]     <= '0;
                pattern_reg[k] <= '0;
            end
            len_reg    <= '0;
            idx_reg    <= '0;
            phase_reg  <= 1'b0;
            acc_reg    <= '0;
            sum_reg    <= '0;
            rem_reg    <= '0;
            quot_reg   <= '0;
            mask_reg   <= '0;
            period_reg <= '0;
            balls_reg  <= '0;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            error_reg  <= 1'b0;
            code_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (digit_valid_in) begin
                        buf_reg[0] <= digit_in;
                        len_reg    <= 3'd1;
                        state_reg  <= commit_in ? S_CHECK : S_COLLECT;
                        busy_reg   <= commit_in;
                        idx_reg    <= '0;
                        phase_reg  <= 1'b0;
                        sum_reg    <= '0;
                        mask_reg   <= '0;
                    end else if (commit_in) begin
                        state_reg <= S_ERROR;
                        error_reg <= 1'b1;
                        code_reg  <= ERR_EMPTY;
                    end
                end
                S_COLLECT: begin
                    if (digit_valid_in && len_reg == LEN_MAX) begin
                        state_reg <= S_ERROR;
                        error_reg <= 1'b1;
                        code_reg  <= ERR_OVERFLOW;
                    end else if (digit_valid_in || commit_in) begin
                        if (digit_valid_in) begin
                            buf_reg[len_reg] <= digit_in;
                            len_reg          <= len_reg + 3'd1;
                        end
                        if (commit_in) begin
                            state_reg <= S_CHECK;
                            busy_reg  <= 1'b1;
                            idx_reg   <= '0;
                            phase_reg <= 1'b0;
                            sum_reg   <= '0;
                            mask_reg  <= '0;
                        end
                    end
                end
                S_CHECK: begin
`ifdef SITESWAP_REJECT_ZERO_EN
                    if (!phase_reg && cur_digit == '0) begin
                        state_reg <= S_ERROR;
                        busy_reg  <= 1'b0;
                        error_reg <= 1'b1;
                        code_reg  <= ERR_ZERO;
                    end else
`endif
                    if (!land_ok) begin
                        acc_reg   <= cand - len4;
                        phase_reg <= 1'b1;
                    end else if (mask_reg[land]) begin
                        state_reg <= S_ERROR;
                        busy_reg  <= 1'b0;
                        error_reg <= 1'b1;
                        code_reg  <= ERR_INVALID;
                    end else begin
                        mask_reg[land] <= 1'b1;
                        sum_reg        <= sum_next;
                        phase_reg      <= 1'b0;
                        if (idx_reg == len_reg - 3'd1) begin
                            state_reg <= S_DIVIDE;
                            rem_reg   <= sum_next;
                            quot_reg  <= '0;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end
                end
                S_DIVIDE: begin
                    if (rem_reg >= len6) begin
                        rem_reg  <= rem_reg - len6;
                        quot_reg <= quot_reg + 3'd1;
                    end else begin
                        busy_reg <= 1'b0;
                        if (rem_reg != '0 || quot_reg == '0) begin
                            state_reg <= S_ERROR;
                            error_reg <= 1'b1;
                            code_reg  <= (rem_reg != '0) ? ERR_INVALID : ERR_EMPTY;
                        end else begin
                            state_reg   <= S_PRESENT;
                            valid_reg   <= 1'b1;
                            period_reg  <= len_reg;
                            balls_reg   <= quot_reg;
                            pattern_reg <= buf_reg;
                        end
                    end
                end
                S_PRESENT, S_ERROR: begin
                    state_reg <= state_reg;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_pattern
            assign pattern_out[gi*DIGIT_W +: DIGIT_W] = pattern_reg[gi];
        end
    endgenerate

    assign period_out        = period_reg;
    assign num_balls_out     = balls_reg;
    assign pattern_valid_out = valid_reg;
    assign busy_out          = busy_reg;
    assign error_out         = error_reg;
    assign error_code_out    = code_reg;

endmodule
